// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter.
// Grant encoding, default widths, base address and word shift.
package arbiter_pkg;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch / LSU / memory-macro bundle for the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  dm_req_valid;
  logic                  dm_req_ready;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wd;
  logic                  dm_rsp_valid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_err;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid,
    output if_rdata, if_err,
    input  dm_req_valid, dm_we,
    input  dm_addr, dm_wd,
    output dm_req_ready, dm_rsp_valid,
    output dm_rdata, dm_err,
    output mem_addr, mem_wd,
    output mem_we, mem_re,
    input  mem_rd
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid,
    input  if_rdata, if_err,
    output dm_req_valid, dm_we,
    output dm_addr, dm_wd,
    input  dm_req_ready, dm_rsp_valid,
    input  dm_rdata, dm_err,
    input  mem_addr, mem_wd,
    input  mem_we, mem_re,
    output mem_rd
  );

endinterface

// File: rtl/mem_port_arbiter_addr_xlate.sv
// Byte address to word index translation.
// Flags misaligned, below-base and past-end accesses.
module addr_xlate
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(DEF_BASE_ADDR)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] off;
  logic mis, below, past;

  assign off   = addr - BASE_ADDR;
  assign idx   = off >> WORD_SHIFT;
  assign mis   = addr[WORD_SHIFT-1:0] != '0;
  assign below = addr < BASE_ADDR;
  assign past  = idx >= ADDR_WIDTH'(MEM_DEPTH);
  assign err   = mis | below | past;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (fetch + LSU) onto a single async-read memory.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin ties.
module mem_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);

  logic [ADDR_WIDTH-1:0] if_idx, dm_idx, sel_idx;
  logic if_bad, dm_bad, sel_bad, sel_we;
  logic gnt_if, gnt_dm, tie_if;
  logic granted, legal;

  logic                  if_vld_q, dm_vld_q;
  logic [DATA_WIDTH-1:0] if_rd_q, dm_rd_q;
  logic                  if_err_q, dm_err_q;

  addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_if_xlate (
    .addr(bus.if_addr),
    .idx (if_idx),
    .err (if_bad)
  );

  addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_dm_xlate (
    .addr(bus.dm_addr),
    .idx (dm_idx),
    .err (dm_bad)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Remember the last winner so ties alternate.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= GNT_IF;
    else if (gnt_if)
      last_grant <= GNT_IF;
    else if (gnt_dm)
      last_grant <= GNT_DM;
  end

  assign tie_if = last_grant == GNT_DM;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // Count consecutive cycles a waiting fetch loses.
  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (bus.if_req_valid && !gnt_if) begin
      if (starve_cnt != LIM)
        starve_cnt <= starve_cnt + SW'(1);
    end else
      starve_cnt <= '0;
  end

  assign tie_if = starve_cnt == LIM;
`endif

  // Single grant per cycle; nothing granted in reset.
  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (rst_n) begin
      if (bus.if_req_valid && bus.dm_req_valid) begin
        gnt_if = tie_if;
        gnt_dm = !tie_if;
      end else begin
        gnt_if = bus.if_req_valid;
        gnt_dm = bus.dm_req_valid;
      end
    end
  end

  // Route the winner's translated address.
  always_comb begin
    sel_idx = '0;
    sel_bad = 1'b0;
    sel_we  = 1'b0;
    unique case (1'b1)
      gnt_dm: begin
        sel_idx = dm_idx;
        sel_bad = dm_bad;
        sel_we  = bus.dm_we;
      end
      gnt_if: begin
        sel_idx = if_idx;
        sel_bad = if_bad;
      end
      default: ;
    endcase
  end

  assign granted = gnt_if | gnt_dm;
  assign legal   = granted & ~sel_bad;

  assign bus.if_req_ready = gnt_if;
  assign bus.dm_req_ready = gnt_dm;

  assign bus.mem_addr =
    legal ? DATA_WIDTH'(sel_idx) : '0;
  assign bus.mem_wd = legal ? bus.dm_wd : '0;
  assign bus.mem_we = legal & sel_we;
  assign bus.mem_re = legal & ~sel_we;

  // Capture responses at the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_vld_q <= 1'b0;
      if_rd_q  <= '0;
      if_err_q <= 1'b0;
      dm_vld_q <= 1'b0;
      dm_rd_q  <= '0;
      dm_err_q <= 1'b0;
    end else begin
      if_vld_q <= gnt_if;
      dm_vld_q <= gnt_dm;
      if (gnt_if) begin
        if_rd_q  <= if_bad ? '0 : bus.mem_rd;
        if_err_q <= if_bad;
      end
      if (gnt_dm) begin
        dm_rd_q  <= (dm_bad || bus.dm_we) ?
                    '0 : bus.mem_rd;
        dm_err_q <= dm_bad;
      end
    end
  end

  assign bus.if_rsp_valid = if_vld_q;
  assign bus.if_rdata     = if_rd_q;
  assign bus.if_err       = if_err_q;
  assign bus.dm_rsp_valid = dm_vld_q;
  assign bus.dm_rdata     = dm_rd_q;
  assign bus.dm_err       = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with response scoreboard.
// Honours ARB_ROUND_ROBIN_EN for the contention pattern.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  localparam logic [31:0] B = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_n;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  bit          wr_vld [1024];
  logic [31:0] wr_dat [1024];

  function automatic logic [31:0] init_val(int i);
    return (i == 2) ? 32'hDEAD_BEEF
                    : 32'hA000_0000 + 32'(i);
  endfunction

  always @(posedge clk)
    if (bus.mem_we === 1'b1) begin
      wr_vld[bus.mem_addr[9:0]] <= 1'b1;
      wr_dat[bus.mem_addr[9:0]] <= bus.mem_wd;
    end

  assign bus.mem_rd = wr_vld[bus.mem_addr[9:0]] ?
    wr_dat[bus.mem_addr[9:0]] :
    init_val(int'(bus.mem_addr[9:0]));

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  rsp_t if_q[$];
  rsp_t dm_q[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic mon();
    rsp_t r;
    if (if_q.size() > 0) begin
      r = if_q.pop_front();
      chk("if_rsp_vld", bus.if_rsp_valid, 1);
      chk("if_rdata", bus.if_rdata, r.d);
      chk("if_err", bus.if_err, r.e);
    end else
      chk("if_rsp_idle", bus.if_rsp_valid, 0);
    if (dm_q.size() > 0) begin
      r = dm_q.pop_front();
      chk("dm_rsp_vld", bus.dm_rsp_valid, 1);
      chk("dm_rdata", bus.dm_rdata, r.d);
      chk("dm_err", bus.dm_err, r.e);
    end else
      chk("dm_rsp_idle", bus.dm_rsp_valid, 0);
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    mon();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic iv, logic [31:0] ia,
                     logic dv, logic dwe,
                     logic [31:0] da, logic [31:0] dwd);
    bus.if_req_valid = iv;
    bus.if_addr      = ia;
    bus.dm_req_valid = dv;
    bus.dm_we        = dwe;
    bus.dm_addr      = da;
    bus.dm_wd        = dwd;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
    cyc_begin();
    chk("idle_re", bus.mem_re, 0);
    chk("idle_addr", bus.mem_addr, 0);
    cyc_end();
  endtask

  initial begin
    logic e;
    rst_n = 1'b0;
    drv(1, B, 1, 1, B + 4, 32'h5555_5555);

    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      chk("rst_if_rdy", bus.if_req_ready, 0);
      chk("rst_dm_rdy", bus.dm_req_ready, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_re", bus.mem_re, 0);
`ifndef ARB_ROUND_ROBIN_EN
      chk("rst_starve", 32'(dut.starve_cnt), 0);
`endif
      cyc_end();
    end
    rst_n = 1'b1;
    idle();

    drv(1, B + 8, 0, 0, 0, 0);
    cyc_begin();
    chk("t1_if_rdy", bus.if_req_ready, 1);
    chk("t1_dm_rdy", bus.dm_req_ready, 0);
    chk("t1_addr", bus.mem_addr, 2);
    chk("t1_re", bus.mem_re, 1);
    if_q.push_back('{32'hDEAD_BEEF, 1'b0});
    cyc_end();
    idle();

    drv(0, 0, 1, 1, B + 16, 32'h1234_5678);
    cyc_begin();
    chk("wr_rdy", bus.dm_req_ready, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_re", bus.mem_re, 0);
    chk("wr_addr", bus.mem_addr, 4);
    chk("wr_wd", bus.mem_wd, 32'h1234_5678);
    dm_q.push_back('{32'h0, 1'b0});
    cyc_end();

    drv(1, B + 16, 0, 0, 0, 0);
    cyc_begin();
    chk("rb_rdy", bus.if_req_ready, 1);
    chk("rb_addr", bus.mem_addr, 4);
    if_q.push_back('{32'h1234_5678, 1'b0});
    cyc_end();
    idle();

    drv(0, 0, 1, 0, B + 8, 0);
    cyc_begin();
    dm_q.push_back('{32'hDEAD_BEEF, 1'b0});
    cyc_end();
    idle();
    drv(0, 0, 0, 0, 0, 0);
    cyc_begin();
    chk("hold_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    cyc_end();

    drv(0, 0, 1, 0, B + 2, 0);
    cyc_begin();
    chk("mis_rdy", bus.dm_req_ready, 1);
    chk("mis_re", bus.mem_re, 0);
    dm_q.push_back('{32'h0, 1'b1});
    cyc_end();

    drv(1, B + 32'h1000, 0, 0, 0, 0);
    cyc_begin();
    chk("oor_rdy", bus.if_req_ready, 1);
    chk("oor_re", bus.mem_re, 0);
    if_q.push_back('{32'h0, 1'b1});
    cyc_end();

    drv(1, B - 4, 0, 0, 0, 0);
    cyc_begin();
    chk("low_rdy", bus.if_req_ready, 1);
    chk("low_re", bus.mem_re, 0);
    if_q.push_back('{32'h0, 1'b1});
    cyc_end();
    idle();

    for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e = (k % 2) == 1;
`else
      e = (k % 5) == 4;
`endif
      drv(1, B, 1, 0, B + 4, 0);
      cyc_begin();
      chk("ct_if_rdy", bus.if_req_ready, e);
      chk("ct_dm_rdy", bus.dm_req_ready, !e);
      chk("ct_addr", bus.mem_addr, e ? 0 : 1);
      if (e) if_q.push_back('{32'hA000_0000, 1'b0});
      else   dm_q.push_back('{32'hA000_0001, 1'b0});
      cyc_end();
    end

    for (int k = 0; k < 3; k++) begin
      drv(1, B + 32'(4 * k), 0, 0, 0, 0);
      cyc_begin();
      chk("b2b_rdy", bus.if_req_ready, 1);
      if_q.push_back('{(k == 2) ? 32'hDEAD_BEEF :
                      32'hA000_0000 + 32'(k), 1'b0});
      cyc_end();
    end
    idle();

    drv(1, B, 0, 0, 0, 0);
    cyc_begin();
    if_q.push_back('{32'hA000_0000, 1'b0});
    cyc_end();
    drv(1, B + 4, 0, 0, 0, 0);
    cyc_begin();
    if_q.push_back('{32'hA000_0001, 1'b0});
    cyc_end();
    rst_n = 1'b0;
    drv(1, B + 8, 1, 1, B + 12, 32'hFFFF_FFFF);
    cyc_begin();
    chk("mr_if_rdy", bus.if_req_ready, 0);
    chk("mr_dm_rdy", bus.dm_req_ready, 0);
    chk("mr_we", bus.mem_we, 0);
    cyc_end();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    cyc_begin();
    chk("mr_rdata_clr", bus.if_rdata, 0);
    cyc_end();

    drv(0, 0, 1, 0, B + 12, 0);
    cyc_begin();
    dm_q.push_back('{32'hA000_0003, 1'b0});
    cyc_end();
    idle();

    chk("q_empty", 32'(if_q.size() + dm_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
